// File: rtl/mux_nway_rr_if.sv
// mux_nway_rr_if: N producer channels and one consumer port, each with valid/ready.
interface mux_nway_rr_if #(
   parameter int WIDTH = 16,
   parameter int N     = 8
);
   localparam int SELW = $clog2(N);
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic               mode;
   logic [SELW-1:0]    sel;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_chan;
   logic               out_valid;
   logic               out_ready;
   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );
   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/mux_nway_rr.sv
// mux_nway_rr: N-way fixed-select / round-robin stream merger with one registered output stage.
module mux_nway_rr #(
   parameter int WIDTH = 16,
   parameter int N     = 8
) (
   input logic          clk,
   input logic          reset,
   mux_nway_rr_if.slave bus
);
   localparam int SELW = $clog2(N);
   logic [SELW-1:0]  r_ptr;
   logic [SELW-1:0]  r_chan;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             w_load;
   logic             w_gnt;
   logic [SELW-1:0]  w_g;
   logic [WIDTH-1:0] w_d;
   assign w_load = !r_valid || bus.out_ready;
   always_comb begin
      w_gnt = 1'b0;
      w_g   = '0;
      w_d   = '0;
      if (!bus.mode) begin
         for (int i = 0; i < N; i++)
            if (bus.in_valid[i] && bus.sel == SELW'(i)) begin
               w_gnt = 1'b1;
               w_g   = SELW'(i);
               w_d   = bus.in_data[i*WIDTH +: WIDTH];
            end
      end else begin
         // lowest valid index <= ptr first, then any valid index above ptr overrides it
         for (int i = N - 1; i >= 0; i--)
            if (bus.in_valid[i] && SELW'(i) <= r_ptr) begin
               w_gnt = 1'b1;
               w_g   = SELW'(i);
               w_d   = bus.in_data[i*WIDTH +: WIDTH];
            end
         for (int i = N - 1; i >= 0; i--)
            if (bus.in_valid[i] && SELW'(i) > r_ptr) begin
               w_gnt = 1'b1;
               w_g   = SELW'(i);
               w_d   = bus.in_data[i*WIDTH +: WIDTH];
            end
      end
   end
   assign bus.in_ready = (w_load && w_gnt && !reset) ? N'(1) << w_g : '0;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_chan  <= '0;
         r_ptr   <= SELW'(N - 1);
      end else if (w_load && w_gnt) begin
         r_valid <= 1'b1;
         r_data  <= w_d;
         r_chan  <= w_g;
         r_ptr   <= w_g;
      end else if (r_valid && bus.out_ready) begin
         r_valid <= 1'b0;
      end
   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_data;
   assign bus.out_chan  = r_chan;
   a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.in_ready));
   a_stall_hold: assert property (@(posedge clk) disable iff (reset)
      r_valid && !bus.out_ready |=> r_valid && $stable(r_data) && $stable(r_chan));
endmodule
